exc_ctrl: RTL

- Exception/interrupt controller at the MEM stage; acts as the initiator of all CP0 exception-side writes.
- Collects per-instruction exception flags, ERET and synchronized external interrupts, and reads CP0 Status/Cause/EPC.
- Picks the highest-priority event and produces the registered CP0 update pulses, the pipeline flush and the PC redirect to the exception vector or EPC.

---
 rtl/exc_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt controller: selects the highest-priority event and
// issues registered CP0 write pulses, pipeline flush and PC redirect.
module exc_ctrl #(
    parameter int                WIDTH       = 32,
    parameter logic [WIDTH-1:0]  EXC_VECTOR  = 32'hBFC00380,
    parameter int                SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] mem_pc,
    input  logic             mem_bd,
    input  logic [WIDTH-1:0] mem_badvaddr,
    input  logic             exc_if_adel,
    input  logic             exc_ri,
    input  logic             exc_ov,
    input  logic             exc_sys,
    input  logic             exc_bp,
    input  logic             exc_adel,
    input  logic             exc_ades,
    input  logic             eret,
    input  logic [5:0]       hw_int_raw,
    input  logic             timer_int,
    input  logic [WIDTH-1:0] status_in,
    input  logic [WIDTH-1:0] cause_in,
    input  logic [WIDTH-1:0] epc_in,
    output logic [5:0]       hw_int_sync,
    output logic             cause_we,
    output logic             epc_we,
    output logic [4:0]       exc_code,
    output logic             exc_bd,
    output logic [WIDTH-1:0] exc_epc,
    output logic             badvaddr_we,
    output logic [WIDTH-1:0] exc_badvaddr,
    output logic             set_exl,
    output logic             clr_exl,
    output logic             flush,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_e;

    state_e                       state_q, state_d;
    logic [SYNC_STAGES-1:0][5:0]  sync_q, sync_d;
    logic                         cause_we_q, cause_we_d;
    logic                         epc_we_q, epc_we_d;
    logic [4:0]                   exc_code_q, exc_code_d;
    logic                         exc_bd_q, exc_bd_d;
    logic [WIDTH-1:0]             exc_epc_q, exc_epc_d;
    logic                         badvaddr_we_q, badvaddr_we_d;
    logic [WIDTH-1:0]             exc_badvaddr_q, exc_badvaddr_d;
    logic                         set_exl_q, set_exl_d;
    logic                         clr_exl_q, clr_exl_d;
    logic                         flush_q, flush_d;
    logic                         redirect_valid_q, redirect_valid_d;
    logic [WIDTH-1:0]             redirect_pc_q, redirect_pc_d;
    logic                         busy_q, busy_d;

    logic                         int_pending;
    logic                         any_exc;
    logic [4:0]                   code_sel;
    logic                         bad_we_sel;
    logic [WIDTH-1:0]             bad_addr_sel;

    // Timer interrupt joins line 5 only at the last stage: it is already synchronous.
    always_comb begin
        sync_d[0] = hw_int_raw;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        sync_d[SYNC_STAGES-1][5] = sync_q[SYNC_STAGES-2][5] | timer_int;
    end

    assign int_pending = (|(cause_in[15:8] & status_in[15:8])) & status_in[0] & ~status_in[1];
    assign any_exc     = int_pending | exc_if_adel | exc_ri | exc_ov | exc_sys
                       | exc_bp | exc_adel | exc_ades;

    always_comb begin
        code_sel     = 5'h00;
        bad_we_sel   = 1'b0;
        bad_addr_sel = '0;
        if (int_pending) begin
            code_sel = 5'h00;
        end else if (exc_if_adel) begin
            code_sel     = 5'h04;
            bad_we_sel   = 1'b1;
            bad_addr_sel = mem_pc;
        end else if (exc_ri) begin
            code_sel = 5'h0A;
        end else if (exc_ov) begin
            code_sel = 5'h0C;
        end else if (exc_sys) begin
            code_sel = 5'h08;
        end else if (exc_bp) begin
            code_sel = 5'h09;
        end else if (exc_adel) begin
            code_sel     = 5'h04;
            bad_we_sel   = 1'b1;
            bad_addr_sel = mem_badvaddr;
        end else if (exc_ades) begin
            code_sel     = 5'h05;
            bad_we_sel   = 1'b1;
            bad_addr_sel = mem_badvaddr;
        end
    end

    // NOTE: every output defaults to 0 first, so no path leaves a value held (no latch)
    // and each write/redirect output is naturally a one-cycle pulse.
    always_comb begin
        state_d          = state_q;
        cause_we_d       = 1'b0;
        epc_we_d         = 1'b0;
        exc_code_d       = 5'h00;
        exc_bd_d         = 1'b0;
        exc_epc_d        = '0;
        badvaddr_we_d    = 1'b0;
        exc_badvaddr_d   = '0;
        set_exl_d        = 1'b0;
        clr_exl_d        = 1'b0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        busy_d           = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_valid && (any_exc || eret)) begin
                    state_d          = FLUSH;
                    busy_d           = 1'b1;
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                    if (any_exc) begin
                        cause_we_d     = 1'b1;
                        set_exl_d      = 1'b1;
                        exc_code_d     = code_sel;
                        redirect_pc_d  = EXC_VECTOR;
                        badvaddr_we_d  = bad_we_sel;
                        exc_badvaddr_d = bad_addr_sel;
                        // A nested exception (EXL set) must not clobber the saved EPC.
                        if (!status_in[1]) begin
                            epc_we_d  = 1'b1;
                            exc_bd_d  = mem_bd;
                            exc_epc_d = mem_bd ? (mem_pc - WIDTH'(4)) : mem_pc;
                        end
                    end else begin
                        clr_exl_d     = 1'b1;
                        redirect_pc_d = epc_in;
                    end
                end
            end
            FLUSH: begin
                state_d = DRAIN;
                busy_d  = 1'b1;
                flush_d = 1'b1;
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            sync_q           <= '0;
            cause_we_q       <= 1'b0;
            epc_we_q         <= 1'b0;
            exc_code_q       <= 5'h00;
            exc_bd_q         <= 1'b0;
            exc_epc_q        <= '0;
            badvaddr_we_q    <= 1'b0;
            exc_badvaddr_q   <= '0;
            set_exl_q        <= 1'b0;
            clr_exl_q        <= 1'b0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            sync_q           <= sync_d;
            cause_we_q       <= cause_we_d;
            epc_we_q         <= epc_we_d;
            exc_code_q       <= exc_code_d;
            exc_bd_q         <= exc_bd_d;
            exc_epc_q        <= exc_epc_d;
            badvaddr_we_q    <= badvaddr_we_d;
            exc_badvaddr_q   <= exc_badvaddr_d;
            set_exl_q        <= set_exl_d;
            clr_exl_q        <= clr_exl_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            busy_q           <= busy_d;
        end
    end

    assign hw_int_sync    = sync_q[SYNC_STAGES-1];
    assign cause_we       = cause_we_q;
    assign epc_we         = epc_we_q;
    assign exc_code       = exc_code_q;
    assign exc_bd         = exc_bd_q;
    assign exc_epc        = exc_epc_q;
    assign badvaddr_we    = badvaddr_we_q;
    assign exc_badvaddr   = exc_badvaddr_q;
    assign set_exl        = set_exl_q;
    assign clr_exl        = clr_exl_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign busy           = busy_q;

endmodule
